// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver: shadow value register, prescaled digit
// scan with one blank cycle per slot, optional leading-zero blanking and output polarity.
module seg7_scan_driver #(
  parameter int N_DIGITS   = 4,
  parameter int DIV        = 50000,
  parameter int BLANK_LZ   = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   digit_sel
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [4*N_DIGITS-1:0] shadow_value_reg;
  logic [N_DIGITS-1:0]   shadow_dp_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [IDX_W-1:0]      idx_reg;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h7E;
      4'h1: decode = 7'h30;
      4'h2: decode = 7'h6D;
      4'h3: decode = 7'h79;
      4'h4: decode = 7'h33;
      4'h5: decode = 7'h5B;
      4'h6: decode = 7'h5F;
      4'h7: decode = 7'h70;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h7B;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h1F;
      4'hC: decode = 7'h4E;
      4'hD: decode = 7'h3D;
      4'hE: decode = 7'h4F;
      default: decode = 7'h47;
    endcase
  endfunction

  // Load only touches the shadow registers, so the scan timing is never disturbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_value_reg <= '0;
      shadow_dp_reg    <= '0;
      cnt_reg          <= '0;
      idx_reg          <= '0;
    end else begin
      if (load) begin
        shadow_value_reg <= value;
        shadow_dp_reg    <= dp_in;
      end
      if (cnt_reg == CNT_W'(DIV - 1)) begin
        cnt_reg <= '0;
        if (idx_reg == IDX_W'(N_DIGITS - 1))
          idx_reg <= '0;
        else
          idx_reg <= idx_reg + 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  logic [3:0]          nib [N_DIGITS];
  logic [N_DIGITS-1:0] sel_onehot;
  logic [N_DIGITS-1:0] upper_zero;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign nib[gi]        = shadow_value_reg[4*gi +: 4];
      assign sel_onehot[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // upper_zero[i] is set when nibbles i..N_DIGITS-1 are all zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    upper_zero = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above    = zero_above & (nib[i] == 4'h0);
      upper_zero[i] = zero_above;
    end
  end

  logic                active;
  logic [6:0]          seg_l;
  logic                dp_l;
  logic [N_DIGITS-1:0] sel_l;

  assign active = (cnt_reg != '0);

  always_comb begin
    seg_l = '0;
    dp_l  = 1'b0;
    sel_l = '0;
    if (active) begin
      sel_l = sel_onehot;
      dp_l  = shadow_dp_reg[idx_reg];
      if (!((BLANK_LZ != 0) && (idx_reg != '0) && upper_zero[idx_reg]))
        seg_l = decode(nib[idx_reg]);
    end
  end

  generate
    if (ACTIVE_LOW != 0) begin : g_active_low
      assign segments  = ~seg_l;
      assign dp        = ~dp_l;
      assign digit_sel = ~sel_l;
    end else begin : g_active_high
      assign segments  = seg_l;
      assign dp        = dp_l;
      assign digit_sel = sel_l;
    end
  endgenerate

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three variants share one stimulus stream; a
// reference model predicts every cycle's outputs into a queue that is popped after each edge.
module tb_seg7_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;

  logic [6:0] seg0, seg1, seg2;
  logic       dp0, dp1, dp2;
  logic [3:0] sel0, sel1, sel2;

  seg7_scan_driver #(.N_DIGITS(N), .DIV(DIV), .BLANK_LZ(0), .ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .segments(seg0), .dp(dp0), .digit_sel(sel0));
  seg7_scan_driver #(.N_DIGITS(N), .DIV(DIV), .BLANK_LZ(1), .ACTIVE_LOW(0)) dut1 (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .segments(seg1), .dp(dp1), .digit_sel(sel1));
  seg7_scan_driver #(.N_DIGITS(N), .DIV(DIV), .BLANK_LZ(1), .ACTIVE_LOW(1)) dut2 (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .segments(seg2), .dp(dp2), .digit_sel(sel2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int          m_cnt, m_idx;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [35:0] exp_q [$];
  logic [35:0] e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  function automatic logic [11:0] expect_one(input bit blz, input bit al);
    logic [3:0]  s;
    logic [6:0]  g;
    logic        d;
    logic [15:0] upper;
    s = '0; g = '0; d = 1'b0;
    if (m_cnt != 0) begin
      s[m_idx] = 1'b1;
      upper = m_val >> (4 * m_idx);
      d = m_dp[m_idx];
      if (!(blz && m_idx > 0 && upper == 16'h0))
        g = seg_tbl[upper[3:0]];
    end
    if (al) begin
      s = ~s; g = ~g; d = ~d;
    end
    return {s, g, d};
  endfunction

  function automatic logic [35:0] expect_all();
    return {expect_one(1'b0, 1'b0), expect_one(1'b1, 1'b0), expect_one(1'b1, 1'b1)};
  endfunction

  function automatic logic [35:0] observed();
    return {sel0, seg0, dp0, sel1, seg1, dp1, sel2, seg2, dp2};
  endfunction

  // Drive one cycle of stimulus, predict the post-edge state, then advance past the edge.
  task automatic drive(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] d);
    rst = r; load = ld; value = v; dp_in = d;
    if (r) begin
      m_cnt = 0; m_idx = 0; m_val = '0; m_dp = '0;
    end else begin
      if (ld) begin
        m_val = v; m_dp = d;
      end
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % N;
      end else begin
        m_cnt++;
      end
    end
    exp_q.push_back(expect_all());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 16'h0, 4'h0);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, observed(), e);
      end
    end
    checks++;
    if ({sel0, seg0} !== 11'h0) begin
      errors++;
      $display("FAIL reset_blank sel=%b seg=%b exp sel=0000 seg=0000000", sel0, seg0);
    end
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b0, 16'h0, 4'h0);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL first_slot cyc=%0d got=%h exp=%h", cyc, observed(), e);
      end
      if (k <= 3) begin
        checks++;
        if (sel0 !== 4'b0001 || seg0 !== 7'b1111110) begin
          errors++;
          $display("FAIL first_slot_lit k=%0d sel=%b seg=%b exp sel=0001 seg=1111110", k, sel0, seg0);
        end
      end
    end
  endtask

  task automatic test_decode();
    logic [15:0] vals [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 17; k++) begin
        drive(1'b0, k == 0, vals[j], 4'h0);
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e) begin
          errors++;
          $display("FAIL decode val=%h cyc=%0d got=%h exp=%h", vals[j], cyc, observed(), e);
        end
        if (vals[j] == 16'hBA98 && m_cnt != 0 && m_idx == 1) begin
          checks++;
          if (seg0 !== 7'b1111011) begin
            errors++;
            $display("FAIL decode_9 seg=%b exp=1111011", seg0);
          end
        end
      end
    end
  endtask

  task automatic test_scan_wrap();
    logic [3:0] seq [20] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h4,
                             4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h1};
    drive(1'b1, 1'b0, 16'h1234, 4'h0);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e || sel0 !== seq[0]) begin
      errors++;
      $display("FAIL scan k=0 sel=%b exp=%b got=%h model=%h", sel0, seq[0], observed(), e);
    end
    for (int k = 1; k < 20; k++) begin
      drive(1'b0, k == 1, 16'h1234, 4'h0);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e || sel0 !== seq[k]) begin
        errors++;
        $display("FAIL scan k=%0d sel=%b exp=%b got=%h model=%h", k, sel0, seq[k], observed(), e);
      end
    end
  endtask

  task automatic test_leading_zero();
    for (int k = 0; k < 17; k++) begin
      drive(1'b0, k == 0, 16'h0050, 4'b1000);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL lz_0050 cyc=%0d got=%h exp=%h", cyc, observed(), e);
      end
      if (m_cnt != 0 && m_idx == 3) begin
        checks++;
        if (seg1 !== 7'b0000000 || dp1 !== 1'b1 || sel1 !== 4'b1000) begin
          errors++;
          $display("FAIL lz_digit3 sel=%b seg=%b dp=%b exp 1000/0000000/1", sel1, seg1, dp1);
        end
      end
    end
    for (int k = 0; k < 17; k++) begin
      drive(1'b0, k == 0, 16'h0000, 4'b0000);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL lz_0000 cyc=%0d got=%h exp=%h", cyc, observed(), e);
      end
    end
  endtask

  task automatic test_boundary_load();
    int guard = 0;
    while (m_cnt != DIV - 1 && guard < 2 * DIV) begin
      drive(1'b0, 1'b0, 16'h0, 4'h0);
      e = exp_q.pop_front();
      guard++;
    end
    checks++;
    if (m_cnt != DIV - 1) begin
      errors++;
      $display("FAIL boundary_align cnt=%0d exp=%0d", m_cnt, DIV - 1);
    end
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, k == 0, 16'hAAAA, 4'h0);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL boundary_load cyc=%0d got=%h exp=%h", cyc, observed(), e);
      end
      if (k == 1) begin
        checks++;
        if (seg0 !== 7'b1110111) begin
          errors++;
          $display("FAIL boundary_first seg=%b exp=1110111", seg0);
        end
      end
    end
    drive(1'b1, 1'b1, 16'h5555, 4'hF);
    e = exp_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 16'h5555, 4'hF);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e || (k < 3 && (seg0 !== 7'b1111110 || dp0 !== 1'b0))) begin
        errors++;
        $display("FAIL load_in_reset k=%0d seg=%b dp=%b got=%h exp=%h", k, seg0, dp0, observed(), e);
      end
    end
  endtask

  task automatic test_active_low();
    drive(1'b1, 1'b0, 16'h0008, 4'h0);
    e = exp_q.pop_front();
    checks++;
    if ({sel2, seg2, dp2} !== 12'hFFF || observed() !== e) begin
      errors++;
      $display("FAIL al_reset got=%b%b%b exp all ones", sel2, seg2, dp2);
    end
    for (int k = 1; k < 17; k++) begin
      drive(1'b0, k == 1, 16'h0008, 4'h0);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL al_scan cyc=%0d got=%h exp=%h", cyc, observed(), e);
      end
      if (k == 2) begin
        checks++;
        if (sel2 !== 4'b1110 || seg2 !== 7'b0000000) begin
          errors++;
          $display("FAIL al_digit0 sel=%b seg=%b exp 1110/0000000", sel2, seg2);
        end
      end
      if (m_cnt == 0) begin
        checks++;
        if ({sel2, seg2, dp2} !== 12'hFFF) begin
          errors++;
          $display("FAIL al_blank got=%b%b%b exp all ones", sel2, seg2, dp2);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0;
    m_cnt = 0; m_idx = 0; m_val = '0; m_dp = '0;
    test_reset();
    test_decode();
    test_scan_wrap();
    test_leading_zero();
    test_boundary_load();
    test_active_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for N_DIGITS hexadecimal 7-segment digits that share one segment bus and have one enable per digit.
- It is the parametrised successor of the single-digit hex decoder. It adds:
  - a shadow value register with a load strobe,
  - a prescaled digit scan,
  - anti-ghosting blank slots,
  - leading-zero blanking,
  - a selectable output polarity.
- It sits between the datapath (the value source) and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned; legal range 1..8.
- DIV, 50000, clock cycles per digit slot; legal minimum 2.
- BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all digits.
- ACTIVE_LOW, 0, 1 = invert segments, dp and digit_sel at the outputs.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  4*N_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is digit i; digit 0 is least significant.
- dp_in  in  N_DIGITS  decimal point request per digit.
- load  in  1  when high at an edge, value and dp_in are captured into the shadow registers.
- segments  out  7  bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g; logical 1 = lit.
- dp  out  1  decimal point of the currently enabled digit.
- digit_sel  out  N_DIGITS  one-hot digit enable, or all-zero during a blank slot.

Behaviour:
- Registers:
  - shadow value, 4*N_DIGITS bits.
  - shadow dp, N_DIGITS bits.
  - cnt, 0..DIV-1.
  - idx, 0..N_DIGITS-1.
- Reset (rst=1 at an edge):
  - shadow value=0, shadow dp=0, cnt=0, idx=0.
  - rst has priority over load.
  - Reset mid-scan restarts the scan at digit 0 on the next cycle.
- Prescaler:
  - cnt increments by 1 every cycle.
  - When cnt=DIV-1, the next edge sets cnt=0 and advances idx by 1.
  - idx wraps from N_DIGITS-1 to 0.
  - With N_DIGITS=1, idx stays 0.
- Load:
  - The shadow registers update at the edge where load=1.
  - The new value is displayed from the following cycle.
  - Load does not disturb cnt or idx, including on a slot-boundary edge.
  - When load=0, the shadow registers hold.
- Outputs are combinational decodes of the registered state only; there is no combinational path from value, dp_in or load.
  - Blank slot: cnt=0, so digit_sel=0, segments=0, dp=0 (logical).
  - Active slot: cnt!=0, so digit_sel has only bit idx set, segments=decode(shadow nibble idx), dp=shadow dp[idx].
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i>0 is blanked when nibbles i..N_DIGITS-1 are all zero.
  - A blanked digit has segments=0 and dp=shadow dp[idx]; digit_sel still asserts normally.
  - Digit 0 always shows its code.
- Decode, logical, hex bit6..0:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
- ACTIVE_LOW=1 inverts segments, dp and digit_sel bitwise after all the rules above. During reset and blank slots the outputs are therefore all ones.
- Timing: the scan period is N_DIGITS*DIV cycles. Each digit is lit for DIV-1 cycles, followed by one blank cycle.

Test Plan:
1. Reset and first slot (N_DIGITS=4, DIV=4, BLANK_LZ=0, ACTIVE_LOW=0):
   - Stimulus: hold rst for 2 cycles, then release.
   - Required: digit_sel=0000 and segments=0000000 while rst=1 and on cycle 0 after release.
   - Required on cycles 1-3: digit_sel=0001 and segments=1111110 (value=0).
2. Full decode sweep:
   - Stimulus: load value=16'h3210, then 16'h7654, 16'hBA98, 16'hFEDC.
   - Required: on each active slot, digit_sel matches idx and segments equals the table entry for that nibble, e.g. digit 1 of 16'hBA98 gives 1111011. Every one of the 16 codes is checked.
3. Scan wrap and blank slots:
   - Stimulus: value=16'h1234, run for 20 cycles.
   - Required digit_sel sequence: 0000, 0001×3, 0000, 0010×3, 0000, 0100×3, 0000, 1000×3, then back to 0000, 0001.
4. Leading-zero blanking (BLANK_LZ=1):
   - Stimulus: value=16'h0050, dp_in=4'b1000.
   - Required: digit 3 shows segments=0000000 with dp=1; digit 2 shows 0000000 with dp=0; digit 1 shows 1011011; digit 0 shows 1111110.
   - Stimulus: value=16'h0000.
   - Required: only digit 0 is lit, with 1111110.
5. Load on a slot boundary and mid-slot:
   - Stimulus: assert load with value=16'hAAAA on the edge where cnt wraps from 3 to 0.
   - Required: idx advances normally; the next active cycle shows 1110111.
   - Required: load while rst=1 is ignored, and the shadow stays 0.
6. ACTIVE_LOW=1:
   - Stimulus: value=16'h0008, with a reset.
   - Required: outputs are all ones during reset and blank slots; digit 0 active shows digit_sel=1110 and segments=0000000.
